// File: rtl/snake_collision_food_if.sv
// snake_collision_food_if: groups the per-move check handshake between the movement stage and the collision/food block.
//   master: drives i_check_start, i_game_restart, i_snake_head, i_snake_length, i_snake_body_flat
//   slave : drives o_food_pos, o_food_eaten, o_game_over, o_check_done, o_busy
interface snake_collision_food_if #(
  parameter int POS_BITS = 13,
  parameter int MAX_LEN  = 64
);
  logic                         i_check_start;
  logic                         i_game_restart;
  logic [POS_BITS-1:0]          i_snake_head;
  logic [$clog2(MAX_LEN):0]     i_snake_length;
  logic [POS_BITS*MAX_LEN-1:0]  i_snake_body_flat;
  logic [POS_BITS-1:0]          o_food_pos;
  logic                         o_food_eaten;
  logic                         o_game_over;
  logic                         o_check_done;
  logic                         o_busy;
  modport master (
    output i_check_start, i_game_restart, i_snake_head, i_snake_length, i_snake_body_flat,
    input  o_food_pos, o_food_eaten, o_game_over, o_check_done, o_busy
  );
  modport slave (
    input  i_check_start, i_game_restart, i_snake_head, i_snake_length, i_snake_body_flat,
    output o_food_pos, o_food_eaten, o_game_over, o_check_done, o_busy
  );
endinterface

// File: rtl/snake_collision_food.sv
// snake_collision_food: self-collision detection, food-eat detection and LFSR-driven food relocation.
//   clk  : system clock
//   rstn : asynchronous active-low reset
//   bus  : slave side of snake_collision_food_if (check request in, food/status out)
module snake_collision_food #(
  parameter int          GRID_W    = 100,
  parameter int          GRID_H    = 75,
  parameter int          MAX_LEN   = 64,
  parameter int          POS_BITS  = 13,
  parameter int          FOOD_INIT = 3760,
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input logic                   clk,
  input logic                   rstn,
  snake_collision_food_if.slave bus
);
  localparam int          LEN_W = $clog2(MAX_LEN) + 1;
  localparam int          IDX_W = $clog2(MAX_LEN);
  localparam logic [31:0] CELLS = 32'(GRID_W * GRID_H);
  typedef enum logic [2:0] {IDLE, SCAN_SELF, CHECK_FOOD, GEN_FOOD, SCAN_FOOD, GAME_OVER} state_t;
  state_t              r_state;
  logic [15:0]         r_lfsr;
  logic [POS_BITS-1:0] r_head;
  logic [POS_BITS-1:0] r_cand;
  logic [POS_BITS-1:0] r_food_pos;
  logic [POS_BITS-1:0] r_body [MAX_LEN];
  logic [LEN_W-1:0]    r_len;
  logic [IDX_W-1:0]    r_idx;
  logic [IDX_W-1:0]    r_food_last;
  logic                r_food_eaten;
  logic                r_game_over;
  logic                r_check_done;
  logic                r_busy;
  logic [LEN_W-1:0]    w_len;
  logic [IDX_W-1:0]    w_food_last;
  logic [POS_BITS-1:0] w_cand;
  logic [POS_BITS-1:0] w_seg;
  logic                w_start;
  always_comb begin
    w_start     = r_state == IDLE && bus.i_check_start;
    w_len       = bus.i_snake_length == '0 ? LEN_W'(1) :
                  bus.i_snake_length > LEN_W'(MAX_LEN) ? LEN_W'(MAX_LEN) : bus.i_snake_length;
    // food scan also covers the tail cell that survives the pending growth
    w_food_last = w_len >= LEN_W'(MAX_LEN) ? IDX_W'(MAX_LEN - 1) : w_len[IDX_W-1:0];
    w_cand      = r_lfsr[POS_BITS-1:0];
    w_seg       = r_body[r_idx];
  end
  always_ff @(posedge clk)
    if (w_start)
      for (int i = 0; i < MAX_LEN; i++) r_body[i] <= bus.i_snake_body_flat[i*POS_BITS +: POS_BITS];
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state      <= IDLE;
      r_lfsr       <= LFSR_SEED;
      r_head       <= '0;
      r_cand       <= '0;
      r_food_pos   <= POS_BITS'(FOOD_INIT);
      r_len        <= '0;
      r_idx        <= '0;
      r_food_last  <= '0;
      r_food_eaten <= 1'b0;
      r_game_over  <= 1'b0;
      r_check_done <= 1'b0;
      r_busy       <= 1'b0;
    end else begin
      r_lfsr       <= {r_lfsr[14:0], r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10]};
      r_food_eaten <= 1'b0;
      r_check_done <= 1'b0;
      case (r_state)
        IDLE:
          if (w_start) begin
            r_head      <= bus.i_snake_head;
            r_len       <= w_len;
            r_food_last <= w_food_last;
            r_idx       <= IDX_W'(1);
            r_busy      <= 1'b1;
            r_state     <= w_len >= LEN_W'(2) ? SCAN_SELF : CHECK_FOOD;
          end
        SCAN_SELF:
          if (w_seg == r_head) begin
            r_game_over  <= 1'b1;
            r_check_done <= 1'b1;
            r_busy       <= 1'b0;
            r_state      <= GAME_OVER;
          end else if ({1'b0, r_idx} == r_len - LEN_W'(1)) r_state <= CHECK_FOOD;
          else r_idx <= r_idx + 1'b1;
        CHECK_FOOD:
          if (r_head == r_food_pos) begin
            r_food_eaten <= 1'b1;
            r_state      <= GEN_FOOD;
          end else begin
            r_check_done <= 1'b1;
            r_busy       <= 1'b0;
            r_state      <= IDLE;
          end
        GEN_FOOD:
          if (32'(w_cand) < CELLS) begin
            r_cand  <= w_cand;
            r_idx   <= '0;
            r_state <= SCAN_FOOD;
          end
        SCAN_FOOD:
          if (w_seg == r_cand) r_state <= GEN_FOOD;
          else if (r_idx == r_food_last) begin
            r_food_pos   <= r_cand;
            r_check_done <= 1'b1;
            r_busy       <= 1'b0;
            r_state      <= IDLE;
          end else r_idx <= r_idx + 1'b1;
        GAME_OVER:
          if (bus.i_game_restart) begin
            r_game_over <= 1'b0;
            r_state     <= IDLE;
          end
        default: r_state <= IDLE;
      endcase
    end
  end
  assign bus.o_food_pos   = r_food_pos;
  assign bus.o_food_eaten = r_food_eaten;
  assign bus.o_game_over  = r_game_over;
  assign bus.o_check_done = r_check_done;
  assign bus.o_busy       = r_busy;
endmodule

// File: tb/tb_snake_collision_food.sv
// tb_snake_collision_food: scoreboard bench for snake_collision_food.
module tb_snake_collision_food;
  localparam int PB = 13;
  localparam int ML = 64;
  typedef struct {int lat; bit eat; bit over;} exp_t;
  logic clk = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;
  snake_collision_food_if #(.POS_BITS(PB), .MAX_LEN(ML)) bus ();
  snake_collision_food dut (.clk(clk), .rstn(rstn), .bus(bus));
  exp_t        sb[$];
  int          vectors = 0;
  int          miscompares = 0;
  int          model_food = 3760;
  logic [PB-1:0] body [ML];
  task automatic clear_body();
    for (int i = 0; i < ML; i++) body[i] = '0;
  endtask
  task automatic start_check(input int head, input int len_raw);
    exp_t e;
    int len;
    int k;
    k = 0;
    len = len_raw < 1 ? 1 : len_raw > ML ? ML : len_raw;
    for (int i = 1; i < len && k == 0; i++) if (int'(body[i]) == head) k = i;
    e.over = k != 0;
    e.eat  = !e.over && head == model_food;
    e.lat  = e.over ? k : len;
    sb.push_back(e);
    @(negedge clk);
    bus.i_snake_head   = PB'(head);
    bus.i_snake_length = 7'(len_raw);
    for (int i = 0; i < ML; i++) bus.i_snake_body_flat[i*PB +: PB] = body[i];
    bus.i_check_start  = 1'b1;
    @(posedge clk);
    #1 bus.i_check_start = 1'b0;
  endtask
  task automatic observe(input bit poke, output int lat_done, output int lat_eat, output int eat_cyc,
                         output int busy_cyc, output bit over, output bit both);
    lat_done = -1; lat_eat = -1; eat_cyc = 0; busy_cyc = 0; over = 1'b0; both = 1'b0;
    for (int n = 1; n <= 5000; n++) begin
      @(posedge clk);
      #1;
      bus.i_check_start = poke && (n == 10 || n == 30);
      if (bus.o_food_eaten) begin
        eat_cyc++;
        if (lat_eat < 0) lat_eat = n;
      end
      if (bus.o_food_eaten && bus.o_check_done) both = 1'b1;
      if (bus.o_busy) busy_cyc++;
      if (bus.o_check_done) begin
        lat_done = n;
        over = bus.o_game_over;
        break;
      end
    end
    bus.i_check_start = 1'b0;
  endtask
  task automatic count_done(input int cycles, output int cnt);
    cnt = 0;
    repeat (cycles) begin
      @(posedge clk);
      #1 if (bus.o_check_done) cnt++;
    end
  endtask
  task automatic test_reset();
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    repeat (3) @(negedge clk);
    rstn = 1'b0;
    @(posedge clk);
    #1;
    vectors++; if (bus.o_food_pos !== PB'(3760)) begin miscompares++; $display("FAIL reset_food: got %0d want 3760", bus.o_food_pos); end
    vectors++; if (bus.o_game_over !== 1'b0) begin miscompares++; $display("FAIL reset_game_over: got %b want 0", bus.o_game_over); end
    vectors++; if (bus.o_busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy: got %b want 0", bus.o_busy); end
    vectors++; if (bus.o_check_done !== 1'b0 || bus.o_food_eaten !== 1'b0) begin miscompares++; $display("FAIL reset_pulses: got done=%b eat=%b want 0 0", bus.o_check_done, bus.o_food_eaten); end
    @(negedge clk);
    rstn = 1'b1;
    model_food = 3760;
  endtask
  task automatic test_no_hit();
    exp_t e;
    int ld, le, ec, bc;
    bit ov, both;
    clear_body();
    body[0] = 3751; body[1] = 3750; body[2] = 3749; body[3] = 3748;
    start_check(3751, 4);
    observe(1'b0, ld, le, ec, bc, ov, both);
    e = sb.pop_front();
    vectors++; if (ld !== e.lat) begin miscompares++; $display("FAIL no_hit_latency: got %0d want %0d", ld, e.lat); end
    vectors++; if (ov !== e.over) begin miscompares++; $display("FAIL no_hit_over: got %b want %b", ov, e.over); end
    vectors++; if (ec !== int'(e.eat)) begin miscompares++; $display("FAIL no_hit_eat: got %0d want %0d", ec, e.eat); end
    vectors++; if (bc !== e.lat - 1) begin miscompares++; $display("FAIL no_hit_busy: got %0d want %0d", bc, e.lat - 1); end
  endtask
  task automatic test_len_clamp();
    exp_t e;
    int ld, le, ec, bc;
    bit ov, both;
    clear_body();
    body[0] = 5;
    start_check(5, 0);
    observe(1'b0, ld, le, ec, bc, ov, both);
    e = sb.pop_front();
    vectors++; if (ld !== e.lat) begin miscompares++; $display("FAIL clamp_zero_latency: got %0d want %0d", ld, e.lat); end
    for (int i = 0; i < ML; i++) body[i] = PB'(1000 + i);
    start_check(1000, 100);
    observe(1'b0, ld, le, ec, bc, ov, both);
    e = sb.pop_front();
    vectors++; if (ld !== e.lat) begin miscompares++; $display("FAIL clamp_high_latency: got %0d want %0d", ld, e.lat); end
  endtask
  task automatic test_collision();
    exp_t e;
    int ld, le, ec, bc, cnt;
    bit ov, both;
    clear_body();
    body[0] = 3750; body[1] = 3850; body[2] = 3851; body[3] = 3750;
    start_check(3750, 4);
    observe(1'b0, ld, le, ec, bc, ov, both);
    e = sb.pop_front();
    vectors++; if (ld !== e.lat) begin miscompares++; $display("FAIL collide_latency: got %0d want %0d", ld, e.lat); end
    vectors++; if (ov !== e.over) begin miscompares++; $display("FAIL collide_over: got %b want %b", ov, e.over); end
    vectors++; if (ec !== 0) begin miscompares++; $display("FAIL collide_eat: got %0d want 0", ec); end
    @(negedge clk);
    bus.i_check_start = 1'b1;
    @(negedge clk);
    bus.i_check_start = 1'b0;
    count_done(10, cnt);
    vectors++; if (cnt !== 0) begin miscompares++; $display("FAIL collide_ignore_start: got %0d dones want 0", cnt); end
    vectors++; if (bus.o_game_over !== 1'b1) begin miscompares++; $display("FAIL collide_sticky: got %b want 1", bus.o_game_over); end
    @(negedge clk);
    bus.i_game_restart = 1'b1;
    bus.i_check_start  = 1'b1;
    @(posedge clk);
    #1;
    bus.i_game_restart = 1'b0;
    bus.i_check_start  = 1'b0;
    vectors++; if (bus.o_game_over !== 1'b0) begin miscompares++; $display("FAIL restart_over: got %b want 0", bus.o_game_over); end
    vectors++; if (bus.o_busy !== 1'b0) begin miscompares++; $display("FAIL restart_busy: got %b want 0", bus.o_busy); end
    count_done(6, cnt);
    vectors++; if (cnt !== 0 || bus.o_busy !== 1'b0) begin miscompares++; $display("FAIL restart_drop_start: got dones=%0d busy=%b want 0 0", cnt, bus.o_busy); end
  endtask
  task automatic test_abort();
    exp_t e;
    int ld, le, ec, bc, lat;
    bit ov, both;
    clear_body();
    body[0] = 3760; body[1] = 3759; body[2] = 3758; body[3] = 3757;
    start_check(3760, 4);
    lat = -1;
    for (int n = 1; n <= 20 && lat < 0; n++) begin
      @(posedge clk);
      #1 if (bus.o_food_eaten) lat = n;
    end
    e = sb.pop_front();
    vectors++; if (lat !== e.lat || !e.eat) begin miscompares++; $display("FAIL abort_eat_latency: got %0d want %0d", lat, e.lat); end
    @(posedge clk);
    #1;
    vectors++; if (bus.o_busy !== 1'b1) begin miscompares++; $display("FAIL abort_busy_before: got %b want 1", bus.o_busy); end
    rstn = 1'b0;
    #1;
    vectors++; if (bus.o_food_pos !== PB'(3760) || bus.o_busy !== 1'b0) begin miscompares++; $display("FAIL abort_reset: got food=%0d busy=%b want 3760 0", bus.o_food_pos, bus.o_busy); end
    vectors++; if (bus.o_check_done !== 1'b0 || bus.o_game_over !== 1'b0) begin miscompares++; $display("FAIL abort_flags: got done=%b over=%b want 0 0", bus.o_check_done, bus.o_game_over); end
    @(negedge clk);
    rstn = 1'b1;
    model_food = 3760;
    clear_body();
    body[0] = 3000; body[1] = 2999; body[2] = 2998; body[3] = 2997;
    start_check(3000, 4);
    observe(1'b0, ld, le, ec, bc, ov, both);
    e = sb.pop_front();
    vectors++; if (ld !== e.lat || ov !== e.over) begin miscompares++; $display("FAIL abort_recheck: got lat=%0d over=%b want %0d %b", ld, ov, e.lat, e.over); end
    vectors++; if (bus.o_food_pos !== PB'(model_food)) begin miscompares++; $display("FAIL abort_food_kept: got %0d want %0d", bus.o_food_pos, model_food); end
  endtask
  task automatic test_full_length();
    exp_t e;
    int ld, le, ec, bc, cnt;
    bit ov, both;
    for (int i = 0; i < ML; i++) body[i] = PB'(1000 + i);
    start_check(1000, 64);
    observe(1'b1, ld, le, ec, bc, ov, both);
    e = sb.pop_front();
    vectors++; if (ld !== e.lat) begin miscompares++; $display("FAIL full_latency: got %0d want %0d", ld, e.lat); end
    vectors++; if (bc !== e.lat - 1) begin miscompares++; $display("FAIL full_busy: got %0d want %0d", bc, e.lat - 1); end
    count_done(80, cnt);
    vectors++; if (cnt !== 0) begin miscompares++; $display("FAIL full_extra_done: got %0d want 0", cnt); end
  endtask
  task automatic test_eat();
    exp_t e;
    int ld, le, ec, bc;
    bit ov, both, in_body;
    clear_body();
    body[0] = 3760; body[1] = 3759; body[2] = 3758; body[3] = 3757; body[4] = 3756;
    start_check(3760, 4);
    observe(1'b0, ld, le, ec, bc, ov, both);
    e = sb.pop_front();
    vectors++; if (le !== e.lat || !e.eat) begin miscompares++; $display("FAIL eat_latency: got %0d want %0d", le, e.lat); end
    vectors++; if (ec !== 1) begin miscompares++; $display("FAIL eat_pulse_width: got %0d want 1", ec); end
    vectors++; if (both !== 1'b0) begin miscompares++; $display("FAIL eat_done_overlap: got %b want 0", both); end
    vectors++; if (!(ld > e.lat)) begin miscompares++; $display("FAIL eat_done_latency: got %0d want >%0d", ld, e.lat); end
    vectors++; if (!(int'(bus.o_food_pos) < 7500)) begin miscompares++; $display("FAIL eat_food_range: got %0d want <7500", bus.o_food_pos); end
    in_body = 1'b0;
    for (int i = 0; i <= 4; i++) if (bus.o_food_pos === body[i]) in_body = 1'b1;
    vectors++; if (in_body !== 1'b0) begin miscompares++; $display("FAIL eat_food_free: got %0d in body want free cell", bus.o_food_pos); end
    vectors++; if (ov !== e.over) begin miscompares++; $display("FAIL eat_over: got %b want %b", ov, e.over); end
  endtask
  initial begin
    bus.i_check_start     = 1'b0;
    bus.i_game_restart    = 1'b0;
    bus.i_snake_head      = '0;
    bus.i_snake_length    = '0;
    bus.i_snake_body_flat = '0;
    test_reset();
    test_no_hit();
    test_len_clamp();
    test_collision();
    test_abort();
    test_full_length();
    test_eat();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
